wb_bridge32to256: RTL

Upsizing Wishbone bridge: accepts single 32-bit accesses from a narrow initiator (DMA engine, debug port, or I/O-side bus master) and issues them as registered 256-bit accesses on the wide system bus. It is the reverse-direction companion of the 256-to-32 I/O bridge, and lets narrow masters reach memory and wide slaves. It maps the 32-bit lane to the correct byte-select slice, extracts the returned lane, and times out stalled transfers.

---
 rtl/wb_bridge32to256.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/wb_bridge32to256.sv
// Upsizing Wishbone bridge: carries single 32-bit initiator accesses onto a 256-bit bus
// as registered wide accesses, returning the addressed lane and timing out stalled slaves.
package wishbone_pkg;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    ERR     = 2'd1,
    DECERR  = 2'd2,
    PROTERR = 2'd3
  } wb_err_t;

  typedef struct packed {
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [7:0]  tid;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [3:0]  cmd;
  } wb_cmd_request32_t;

  typedef struct packed {
    logic         cyc;
    logic         we;
    logic [31:0]  sel;
    logic [31:0]  adr;
    logic [255:0] dat;
    logic [7:0]   tid;
    logic [2:0]   cti;
    logic [1:0]   bte;
    logic [3:0]   cmd;
  } wb_cmd_request256_t;

  typedef struct packed {
    logic        ack;
    wb_err_t     err;
    logic        rty;
    logic        next;
    logic        stall;
    logic [31:0] dat;
    logic [7:0]  tid;
    logic [1:0]  pri;
  } wb_cmd_response32_t;

  typedef struct packed {
    logic         ack;
    wb_err_t      err;
    logic         rty;
    logic         next;
    logic         stall;
    logic [255:0] dat;
    logic [7:0]   tid;
    logic [1:0]   pri;
  } wb_cmd_response256_t;

endpackage

module wb_bridge32to256
  import wishbone_pkg::*;
#(
  parameter logic [7:0]  CHANNEL_TID = 8'h00,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic                rst_i,
  input  logic                clk_i,
  input  wb_cmd_request32_t   s_req,
  output wb_cmd_response32_t  s_resp,
  output wb_cmd_request256_t  m_req,
  input  wb_cmd_response256_t m_resp
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_NACK = 2'd2
  } state_t;

  state_t              state, state_n;
  wb_cmd_request256_t  m_req_n;
  wb_cmd_response32_t  s_resp_n;
  logic [15:0]         cnt, cnt_n;
  logic [2:0]          lane, lane_n;
  logic [7:0]          tid_q, tid_n;
  logic                rsp_seen;

  function automatic wb_cmd_request256_t idle_req();
    wb_cmd_request256_t r;
    r     = '0;
    r.adr = 32'hFFFF_FFFF;
    return r;
  endfunction

  function automatic wb_cmd_request256_t widen_req(input wb_cmd_request32_t n);
    wb_cmd_request256_t r;
    r     = '0;
    r.cyc = 1'b1;
    r.we  = n.we;
    r.cmd = n.cmd;
    r.cti = n.cti;
    r.bte = n.bte;
    r.adr = {n.adr[31:5], n.adr[4:2], 2'b00};
    r.sel = {28'd0, n.sel} << {n.adr[4:2], 2'b00};
    r.dat = {8{n.dat}};
    r.tid = n.tid | CHANNEL_TID;
    return r;
  endfunction

  function automatic logic [31:0] lane_slice(input logic [255:0] d, input logic [2:0] l);
    return d[{l, 5'b00000} +: 32];
  endfunction

  assign rsp_seen = m_resp.ack || (m_resp.err != OK) || m_resp.rty;

  // Priority inside WAIT_ACK: initiator abort, then slave response, then timeout.
  always_comb begin
    state_n  = state;
    m_req_n  = m_req;
    s_resp_n = s_resp;
    cnt_n    = cnt;
    lane_n   = lane;
    tid_n    = tid_q;
    case (state)
      IDLE: begin
        if (s_req.cyc) begin
          m_req_n = widen_req(s_req);
          lane_n  = s_req.adr[4:2];
          tid_n   = s_req.tid;
          cnt_n   = 16'(TIMEOUT);
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!s_req.cyc) begin
          m_req_n  = idle_req();
          s_resp_n = '0;
          state_n  = IDLE;
        end else if (rsp_seen) begin
          s_resp_n     = '0;
          s_resp_n.ack = m_resp.ack;
          s_resp_n.err = m_resp.err;
          s_resp_n.rty = m_resp.rty;
          s_resp_n.dat = lane_slice(m_resp.dat, lane);
          s_resp_n.tid = tid_q;
          s_resp_n.pri = m_resp.pri;
          m_req_n      = idle_req();
          state_n      = WAIT_NACK;
        end else if (cnt == 16'd0) begin
          s_resp_n     = '0;
          s_resp_n.ack = 1'b1;
          s_resp_n.err = ERR;
          s_resp_n.dat = 32'hDEAD_DEAD;
          s_resp_n.tid = tid_q;
          m_req_n      = idle_req();
          state_n      = WAIT_NACK;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      WAIT_NACK: begin
        if (!s_req.cyc) begin
          s_resp_n = '0;
          state_n  = IDLE;
        end
      end
      default: begin
        m_req_n  = idle_req();
        s_resp_n = '0;
        state_n  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      m_req  <= idle_req();
      s_resp <= '0;
      cnt    <= '0;
      lane   <= '0;
      tid_q  <= '0;
    end else begin
      state  <= state_n;
      m_req  <= m_req_n;
      s_resp <= s_resp_n;
      cnt    <= cnt_n;
      lane   <= lane_n;
      tid_q  <= tid_n;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_req.adr[1:0], m_resp.next, m_resp.stall, m_resp.tid};

endmodule
